// File: rtl/seg_pkg.sv
// seg_pkg: shared types and helpers for the seven-segment scan controller.
// Contents: digit count and select width, nibble/select/display typedefs, and
// lz_blank(), the leading-zero rule used when SEG_LEADING_ZERO_BLANK_EN is defined.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEL_W      = 3;

  typedef logic [3:0]       nibble_t;
  typedef logic [SEL_W-1:0] sel_t;

  typedef struct packed {
    logic [31:0] word;
    logic [7:0]  mask;
  } disp_t;

  // True when digit k (k > 0) sits above the highest nonzero nibble of word,
  // i.e. nibbles k..7 are all zero. Digit 0 always shows.
  function automatic logic lz_blank(input logic [31:0] word, input sel_t k);
    logic any_nz;
    any_nz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(k)) && (word[i*4 +: 4] != 4'h0)) any_nz = 1'b1;
    end
    return (k != '0) && !any_nz;
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// seg_tick_gen: digit-slot prescaler. Counts 0..TICK_DIV-1 and wraps; tick is
// high during the last count of each slot.
// Ports: clk (clock), rst_n (async active-low reset), tick (slot-end strobe).
module seg_tick_gen #(
  parameter int unsigned TICK_DIV = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] pcnt_q, pcnt_d;

  always_comb begin
    tick   = (pcnt_q == CntW'(TICK_DIV - 1));
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt_q <= '0;
    else        pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an 8-digit common-anode
// seven-segment display. A written word/mask is held in a pending buffer and
// only goes live at the 7->0 wrap, so a frame never mixes two words.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   wr_valid/wr_ready   write handshake; wr_ready = pending buffer empty
//   wr_data, wr_mask    display word (nibble k -> digit k) and digit enables
//   num, sel, blank     registered nibble, digit index and blank for the decoder
//   frame_done          one-cycle pulse in the cycle sel becomes 0
// Build option: define SEG_LEADING_ZERO_BLANK_EN to also blank leading zero digits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_mask,
  output logic [3:0]  num,
  output logic [2:0]  sel,
  output logic        blank,
  output logic        frame_done
);

  logic    tick;
  sel_t    sel_q, sel_next;
  nibble_t num_q, num_next;
  logic    blank_q, blank_next;
  logic    frame_done_q;
  disp_t   shown_q, shown_next;
  disp_t   pend_q;
  logic    pend_full_q;
  logic    frame_end, commit, xfer;

  seg_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_comb begin
    sel_next   = sel_q + 1'b1;
    frame_end  = tick && (sel_q == sel_t'(NUM_DIGITS - 1));
    commit     = frame_end && pend_full_q;
    xfer       = wr_valid && !pend_full_q;
    // Outputs for the new digit are computed from the word that will be shown
    // after this edge, so digit 0 of a fresh frame already uses a committed word.
    shown_next = commit ? pend_q : shown_q;
    num_next   = shown_next.word[{sel_next, 2'b00} +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    blank_next = ~shown_next.mask[sel_next] | lz_blank(shown_next.word, sel_next);
`else
    blank_next = ~shown_next.mask[sel_next];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q        <= '0;
      num_q        <= '0;
      blank_q      <= 1'b0;
      frame_done_q <= 1'b0;
      shown_q      <= '{word: 32'h0, mask: 8'hFF};
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
    end else begin
      frame_done_q <= frame_end;
      if (xfer) pend_q <= '{word: wr_data, mask: wr_mask};
      // commit needs a full buffer and xfer an empty one, so they never collide
      if (commit)    pend_full_q <= 1'b0;
      else if (xfer) pend_full_q <= 1'b1;
      if (tick) begin
        sel_q   <= sel_next;
        num_q   <= num_next;
        blank_q <= blank_next;
        shown_q <= shown_next;
      end
    end
  end

  assign wr_ready   = !pend_full_q;
  assign num        = num_q;
  assign sel        = sel_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with TICK_DIV=4 (one digit slot = 4 clocks).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [7:0]  wr_mask;
  logic [3:0]  num;
  logic [2:0]  sel;
  logic        blank;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(
    .TICK_DIV(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_mask   (wr_mask),
    .num       (num),
    .sel       (sel),
    .blank     (blank),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Step until sel has just changed to s; bounded to two frames.
  task automatic wait_sel(input logic [2:0] s);
    logic [2:0] prev;
    bit         hit;
    hit = 0;
    for (int i = 0; i < 64; i++) begin
      prev = sel;
      step(1);
      if (sel == s && prev != s) begin
        hit = 1;
        break;
      end
    end
    checks++;
    assert (hit) else begin
      errors++;
      $error("FAIL wait_sel timeout: observed sel %0d expected %0d", sel, s);
    end
  endtask

  task automatic write(input logic [31:0] d, input logic [7:0] m);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_mask  = m;
    step(1);
    wr_valid = 1'b0;
    wr_data  = 32'hFFFF_FFFF;  // must be ignored once the transfer is done
    wr_mask  = 8'h00;
  endtask

  logic [31:0] w;

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    wr_mask  = '0;

    // Reset state
    step(2);
    check("rst_sel", 32'(sel), 0);
    check("rst_num", 32'(num), 0);
    check("rst_blank", 32'(blank), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_frame_done", 32'(frame_done), 0);

    // Slot length and frame wrap
    rst_n = 1'b1;
    step(3);
    check("slot0_len", 32'(sel), 0);
    step(1);
    check("slot1_start", 32'(sel), 1);
    step(27);
    check("pre_wrap_sel", 32'(sel), 7);
    check("pre_wrap_fd", 32'(frame_done), 0);
    step(1);
    check("wrap_sel", 32'(sel), 0);
    check("wrap_fd", 32'(frame_done), 1);
    step(1);
    check("fd_one_cycle", 32'(frame_done), 0);

    // Double-buffered write
    wait_sel(3'd2);
    write(32'h1234_5678, 8'hFF);
    check("wr_busy", 32'(wr_ready), 0);
    check("num_old_s2", 32'(num), 0);
    wait_sel(3'd7);
    check("num_old_s7", 32'(num), 0);
    check("wr_busy_s7", 32'(wr_ready), 0);
    wait_sel(3'd0);
    check("commit_num_s0", 32'(num), 8);
    check("commit_ready", 32'(wr_ready), 1);
    check("commit_fd", 32'(frame_done), 1);
    wait_sel(3'd3);
    check("num_s3", 32'(num), 5);
    wait_sel(3'd7);
    check("num_s7", 32'(num), 1);
    check("blank_s7", 32'(blank), 0);

    // Back-to-back: second word stalls until the commit edge
    wait_sel(3'd1);
    write(32'h8765_4321, 8'hFF);
    wr_valid = 1'b1;
    wr_data  = 32'hCAFE_BABE;
    wr_mask  = 8'hFF;
    wait_sel(3'd7);
    check("b2b_stall", 32'(wr_ready), 0);
    check("b2b_old_num", 32'(num), 1);
    wait_sel(3'd0);
    check("b2b_commit_ready", 32'(wr_ready), 1);
    check("b2b_first_num", 32'(num), 1);
    step(1);
    wr_valid = 1'b0;
    check("b2b_accept", 32'(wr_ready), 0);
    wait_sel(3'd7);
    check("b2b_first_s7", 32'(num), 8);
    wait_sel(3'd0);
    check("b2b_second_s0", 32'(num), 32'hE);
    check("b2b_second_ready", 32'(wr_ready), 1);
    wait_sel(3'd5);
    check("b2b_second_s5", 32'(num), 32'hF);

    // Mask 0F: upper four digits dark, nibbles still tracked
    write(32'h7654_3210, 8'h0F);
    wait_sel(3'd0);
    check("mask_s0_num", 32'(num), 0);
    check("mask_s0_blank", 32'(blank), 0);
    for (int k = 1; k < 8; k++) begin
      wait_sel(3'(k));
      check("mask_num", 32'(num), 32'(k));
      check("mask_blank", 32'(blank), (k >= 4) ? 32'd1 : 32'd0);
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Leading-zero blanking
    w = 32'h0000_0A05;
    write(w, 8'hFF);
    wait_sel(3'd0);
    check("lz_s0_num", 32'(num), 5);
    check("lz_s0_blank", 32'(blank), 0);
    for (int k = 1; k < 8; k++) begin
      wait_sel(3'(k));
      check("lz_num", 32'(num), 32'(w[k*4 +: 4]));
      check("lz_blank", 32'(blank), (k >= 3) ? 32'd1 : 32'd0);
    end
    write(32'h0, 8'hFF);
    wait_sel(3'd0);
    check("lz0_s0_blank", 32'(blank), 0);
    for (int k = 1; k < 8; k++) begin
      wait_sel(3'(k));
      check("lz0_blank", 32'(blank), 1);
    end
`else
    w = 32'h0;
`endif

    // Asynchronous reset mid-slot with a pending word
    wait_sel(3'd1);
    write(32'hDEAD_BEEF, 8'hFF);
    wait_sel(3'd5);
    step(2);
    check("pre_rst_pending", 32'(wr_ready), 0);
    check("pre_rst_sel", 32'(sel), 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sel", 32'(sel), 0);
    check("async_rst_num", 32'(num), 0);
    check("async_rst_blank", 32'(blank), 0);
    check("async_rst_ready", 32'(wr_ready), 1);
    step(2);
    rst_n = 1'b1;
    step(3);
    check("post_rst_slot0", 32'(sel), 0);
    step(1);
    check("post_rst_sel1", 32'(sel), 1);
    check("post_rst_num1", 32'(num), 0);
    check("post_rst_ready", 32'(wr_ready), 1);
    wait_sel(3'd0);
    check("post_rst_no_commit", 32'(num), 0);
    wait_sel(3'd1);
    check("post_rst_no_commit_s1", 32'(num), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
